// File: rtl/mem_bridge.sv
// mem_bridge: splits a 64-bit core access into up to two 32-bit bus beats.
// Ports: clock/reset (async, active low); core_* request side; mem_* bus side.
// Optional ack watchdog: define MEM_BRIDGE_TIMEOUT_EN.
module mem_bridge (
  input  logic        clock,
  input  logic        reset,
  input  logic        core_rd_en,
  input  logic        core_wr_en,
  input  logic [7:0]  core_byte_en,
  input  logic [63:0] core_addr,
  input  logic [63:0] core_wr_data,
  output logic [63:0] core_rd_data,
  output logic        core_busy,
  output logic        mem_stb,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_ack,
  output logic        mem_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [63:0] rdata_q, rdata_d;
  logic        req;
  logic        in_lo, in_hi, beat;

  assign req   = core_rd_en | core_wr_en;
  assign in_lo = (state_q == S_LO);
  assign in_hi = (state_q == S_HI);
  assign beat  = in_lo | in_hi;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       abort;

  // abort on the edge where the count would reach 255
  assign abort = beat & ~mem_ack & (cnt_q == 8'd254);
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = core_addr;
          wdata_d = core_wr_data;
          be_d    = core_byte_en;
          we_d    = core_wr_en;
          rdata_d = '0;
          if (|core_byte_en[3:0])
            state_d = S_LO;
          else if (|core_byte_en[7:4])
            state_d = S_HI;
          else
            state_d = S_DONE;
        end
      end
      S_LO: begin
        if (mem_ack) begin
          if (!we_q) rdata_d[31:0] = mem_rd_data;
          state_d = (|be_q[7:4]) ? S_HI : S_DONE;
        end
`ifdef MEM_BRIDGE_TIMEOUT_EN
        else if (abort) begin
          if (!we_q) rdata_d[31:0] = '1;
          state_d = S_DONE;
        end
`endif
      end
      S_HI: begin
        if (mem_ack) begin
          if (!we_q) rdata_d[63:32] = mem_rd_data;
          state_d = S_DONE;
        end
`ifdef MEM_BRIDGE_TIMEOUT_EN
        else if (abort) begin
          if (!we_q) rdata_d[63:32] = '1;
          state_d = S_DONE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef MEM_BRIDGE_TIMEOUT_EN
  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (state_d != state_q)
      cnt_d = '0;
    else if (beat && !mem_ack)
      cnt_d = cnt_q + 8'd1;
    if (abort)
      err_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  assign core_busy    = beat | ((state_q == S_IDLE) & req);
  assign core_rd_data = rdata_q;
  assign mem_stb      = beat;
  assign mem_we       = beat & we_q;
  assign mem_addr     = beat ? {addr_q[63:3], in_hi, 2'b00} : 64'd0;
  assign mem_sel      = in_lo ? be_q[3:0] :
                        in_hi ? be_q[7:4] : 4'd0;
  assign mem_wr_data  = in_lo ? wdata_q[31:0] :
                        in_hi ? wdata_q[63:32] : 32'd0;

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: directed vector bench for mem_bridge.
// Table of accesses with a zero-wait bus responder plus corner sequences.
module tb_mem_bridge;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        core_rd_en = 1'b0;
  logic        core_wr_en = 1'b0;
  logic [7:0]  core_byte_en = '0;
  logic [63:0] core_addr = '0;
  logic [63:0] core_wr_data = '0;
  logic [63:0] core_rd_data;
  logic        core_busy;
  logic        mem_stb;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data = '0;
  logic        mem_ack = 1'b0;
  logic        mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_bridge dut (
    .clock        (clock),
    .reset        (reset),
    .core_rd_en   (core_rd_en),
    .core_wr_en   (core_wr_en),
    .core_byte_en (core_byte_en),
    .core_addr    (core_addr),
    .core_wr_data (core_wr_data),
    .core_rd_data (core_rd_data),
    .core_busy    (core_busy),
    .mem_stb      (mem_stb),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_sel      (mem_sel),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data  (mem_rd_data),
    .mem_ack      (mem_ack),
    .mem_err      (mem_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  be;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [31:0] lo_rd;
    logic [31:0] hi_rd;
    int          nb;
    logic [63:0] a0;
    logic [3:0]  s0;
    logic [31:0] d0;
    logic [63:0] a1;
    logic [3:0]  s1;
    logic [31:0] d1;
    logic        we;
    logic [63:0] rdata;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [63:0] ba[2];
    logic [3:0]  bs[2];
    logic [31:0] bd[2];
    logic        bw[2];
    int nb;
    int lat;
    nb  = 0;
    lat = 0;
    @(negedge clock);
    core_rd_en   = v.rd;
    core_wr_en   = v.wr;
    core_byte_en = v.be;
    core_addr    = v.addr;
    core_wr_data = v.wdata;
    mem_ack      = 1'b0;
    #1;
    check($sformatf("v%0d busy_req", idx), core_busy, 1);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock);
      #1;
      if (!core_busy) begin
        lat = c;
        break;
      end
      if (mem_stb) begin
        if (nb < 2) begin
          ba[nb] = mem_addr;
          bs[nb] = mem_sel;
          bd[nb] = mem_wr_data;
          bw[nb] = mem_we;
        end
        nb++;
        mem_rd_data = mem_addr[2] ? v.hi_rd : v.lo_rd;
        mem_ack     = 1'b1;
      end else begin
        mem_ack = 1'b0;
      end
    end
    // request dropped in DONE; ack left as-is to show DONE ignores it
    core_rd_en = 1'b0;
    core_wr_en = 1'b0;
    check($sformatf("v%0d latency", idx), lat, v.lat);
    check($sformatf("v%0d beats", idx), nb, v.nb);
    for (int i = 0; i < 2; i++) begin
      if (i < nb && i < v.nb) begin
        check($sformatf("v%0d b%0d addr", idx, i), ba[i],
              (i == 0) ? v.a0 : v.a1);
        check($sformatf("v%0d b%0d sel", idx, i), bs[i],
              (i == 0) ? v.s0 : v.s1);
        check($sformatf("v%0d b%0d wdata", idx, i), bd[i],
              (i == 0) ? v.d0 : v.d1);
        check($sformatf("v%0d b%0d we", idx, i), bw[i], v.we);
      end
    end
    check($sformatf("v%0d rdata", idx), core_rd_data, v.rdata);
    check($sformatf("v%0d err", idx), mem_err, 0);
    @(posedge clock);
    #1;
    mem_ack = 1'b0;
    check($sformatf("v%0d rdata_hold", idx), core_rd_data, v.rdata);
    check($sformatf("v%0d idle_busy", idx), core_busy, 0);
    check($sformatf("v%0d idle_stb", idx), mem_stb, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'hFF, 64'h1004, 64'h0,
                32'h11111111, 32'h22222222, 2,
                64'h1000, 4'hF, 32'h0, 64'h1004, 4'hF, 32'h0,
                1'b0, 64'h22222222_11111111, 3};
    vecs[1] = '{1'b1, 1'b0, 8'h00, 64'h1234, 64'h0,
                32'hFFFFFFFF, 32'hFFFFFFFF, 0,
                64'h0, 4'h0, 32'h0, 64'h0, 4'h0, 32'h0,
                1'b0, 64'h0, 1};
    vecs[2] = '{1'b0, 1'b1, 8'hF0, 64'h2000, 64'hAABBCCDD_00000000,
                32'h0, 32'h0, 1,
                64'h2004, 4'hF, 32'hAABBCCDD, 64'h0, 4'h0, 32'h0,
                1'b1, 64'h0, 2};
    vecs[3] = '{1'b1, 1'b0, 8'h0F, 64'h3007, 64'h0,
                32'h12345678, 32'h9ABCDEF0, 1,
                64'h3000, 4'hF, 32'h0, 64'h0, 4'h0, 32'h0,
                1'b0, 64'h00000000_12345678, 2};
    vecs[4] = '{1'b0, 1'b1, 8'h3C, 64'h40, 64'h11223344_55667788,
                32'h0, 32'h0, 2,
                64'h40, 4'hC, 32'h55667788, 64'h44, 4'h3, 32'h11223344,
                1'b1, 64'h0, 3};
    vecs[5] = '{1'b1, 1'b1, 8'h81, 64'hFFFFFFFF_FFFFFFF9,
                64'hDEADBEEF_CAFEF00D, 32'h5555, 32'h6666, 2,
                64'hFFFFFFFF_FFFFFFF8, 4'h1, 32'hCAFEF00D,
                64'hFFFFFFFF_FFFFFFFC, 4'h8, 32'hDEADBEEF,
                1'b1, 64'h0, 3};
    vecs[6] = '{1'b1, 1'b0, 8'h10, 64'h8, 64'h0,
                32'h0, 32'hA5A5A5A5, 1,
                64'hC, 4'h1, 32'h0, 64'h0, 4'h0, 32'h0,
                1'b0, 64'hA5A5A5A5_00000000, 2};

    // reset state
    #12;
    check("rst stb", mem_stb, 0);
    check("rst we", mem_we, 0);
    check("rst addr", mem_addr, 0);
    check("rst sel", mem_sel, 0);
    check("rst wdata", mem_wr_data, 0);
    check("rst rdata", core_rd_data, 0);
    check("rst err", mem_err, 0);
    check("rst busy", core_busy, 0);
    core_rd_en = 1'b1;
    #1;
    check("rst busy_req", core_busy, 1);
    core_rd_en = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 7; i++)
      run_vec(vecs[i], i);

    // request held through DONE is ignored, restarts from IDLE
    @(negedge clock);
    core_rd_en   = 1'b1;
    core_byte_en = 8'h00;
    core_addr    = 64'h0;
    mem_ack      = 1'b1;
    @(posedge clock); #1;
    check("hold done_busy", core_busy, 0);
    check("hold done_stb", mem_stb, 0);
    @(posedge clock); #1;
    check("hold idle_busy", core_busy, 1);
    check("hold idle_stb", mem_stb, 0);
    @(posedge clock); #1;
    check("hold done2_busy", core_busy, 0);
    core_rd_en = 1'b0;
    mem_ack    = 1'b0;
    @(posedge clock); #1;

    // LO beat with ack delayed 5 cycles
    @(negedge clock);
    core_rd_en   = 1'b1;
    core_byte_en = 8'h0F;
    core_addr    = 64'h500;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clock); #1;
      check($sformatf("wait%0d stb", c), mem_stb, 1);
      check($sformatf("wait%0d addr", c), mem_addr, 64'h500);
      check($sformatf("wait%0d sel", c), mem_sel, 4'hF);
      check($sformatf("wait%0d busy", c), core_busy, 1);
      if (c == 6) begin
        mem_ack     = 1'b1;
        mem_rd_data = 32'h0BADF00D;
      end
    end
    @(posedge clock); #1;
    check("wait done_busy", core_busy, 0);
    check("wait rdata", core_rd_data, 64'h0BADF00D);
    core_rd_en = 1'b0;
    mem_ack    = 1'b0;
    @(posedge clock); #1;

    // reset asserted during the HI beat
    @(negedge clock);
    core_rd_en   = 1'b1;
    core_byte_en = 8'hFF;
    core_addr    = 64'h600;
    @(posedge clock); #1;
    mem_ack     = 1'b1;
    mem_rd_data = 32'h12345678;
    @(posedge clock); #1;
    mem_ack = 1'b0;
    check("rhi stb", mem_stb, 1);
    check("rhi addr", mem_addr, 64'h604);
    #2;
    reset = 1'b0;
    #1;
    check("rhi stb_rst", mem_stb, 0);
    check("rhi addr_rst", mem_addr, 0);
    check("rhi sel_rst", mem_sel, 0);
    check("rhi rdata_rst", core_rd_data, 0);
    check("rhi busy_req", core_busy, 1);
    core_rd_en = 1'b0;
    #1;
    check("rhi busy_idle", core_busy, 0);
    @(negedge clock);
    reset = 1'b1;
    run_vec(vecs[0], 10);

`ifdef MEM_BRIDGE_TIMEOUT_EN
    begin
      int stb_cyc;
      int err_cyc;
      stb_cyc = 0;
      err_cyc = 0;
      @(negedge clock);
      core_rd_en   = 1'b1;
      core_byte_en = 8'hFF;
      core_addr    = 64'h700;
      mem_ack      = 1'b0;
      for (int c = 1; c <= 400; c++) begin
        @(posedge clock); #1;
        if (mem_stb) stb_cyc++;
        if (mem_err) err_cyc++;
        if (!core_busy) break;
      end
      check("wd beat_cycles", stb_cyc, 255);
      check("wd err_now", mem_err, 1);
      check("wd rdata", core_rd_data, 64'h00000000_FFFFFFFF);
      core_rd_en = 1'b0;
      @(posedge clock); #1;
      if (mem_err) err_cyc++;
      check("wd err_pulses", err_cyc, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
